// File: rtl/mux_port.sv
// ---------------------------------------------------------------------------
// mux_port
//
// Memory-mapped serial port for a small CPU bus. The block occupies two
// addresses: a status register at BASE_ADDR and a data register at
// BASE_ADDR+1. Bytes written to the data register are queued in a small TX
// FIFO and serialized onto txd as 8N1 frames. Frames arriving on rxd are
// deserialized into a one-byte holding register read from the data address.
//
// Status byte layout:
//   bit0 rxReady       - holding register contains an unread byte
//   bit1 txNotFull     - TX FIFO can accept another byte
//   bit2 txIdle        - TX FIFO empty and serializer idle
//   bit3 overrun       - a received byte replaced an unread one
//   bit4 framingError  - a frame ended with a low stop bit
//   bit5 txOverflow    - a write was dropped because the FIFO was full
//   bit7:6             - always zero
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   asynchronous, active-high reset
//   addressBus  in   16-bit CPU address
//   writeEnBus  in   CPU write strobe
//   readEnBus   in   CPU read strobe
//   dataOutBus  in   8-bit CPU write data
//   dataInBus   out  8-bit read data, combinational from address and state
//   selected    out  high when addressBus hits either register
//   txd         out  serial transmit line, idle high
//   rxd         in   serial receive line, asynchronous to clock
//
// Parameters:
//   BASE_ADDR     address of the status register
//   CLKS_PER_BIT  clocks per serial bit (even, >= 4)
//   TX_DEPTH      TX FIFO entries (power of 2, >= 2)
// ---------------------------------------------------------------------------
module mux_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic        writeEnBus,
  input  logic        readEnBus,
  input  logic [7:0]  dataOutBus,
  output logic [7:0]  dataInBus,
  output logic        selected,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  // Address decode and qualified bus strobes
  logic w_selStatus;
  logic w_selData;
  logic w_push;
  logic w_overflow;
  logic w_readData;
  logic w_readStatus;

  // TX FIFO
  logic [7:0]     r_fifoMem [TX_DEPTH];
  logic [PTR_W:0] r_wrPtr;
  logic [PTR_W:0] r_rdPtr;
  logic           w_fifoEmpty;
  logic           w_fifoFull;
  logic [7:0]     w_fifoHead;
  logic           w_pop;

  // TX serializer
  txState_t         r_txState;
  logic [CNT_W-1:0] r_txCnt;
  logic [2:0]       r_txBitIdx;
  logic [7:0]       r_txShift;
  logic             r_txd;
  logic             w_txBitEnd;

  // RX synchronizer and deserializer
  logic             r_rxMeta;
  logic             r_rxSync;
  logic             r_rxPrev;
  logic             w_rxFall;
  rxState_t         r_rxState;
  logic [CNT_W-1:0] r_rxCnt;
  logic [2:0]       r_rxBitIdx;
  logic [7:0]       r_rxShift;
  logic             w_rxBitEnd;
  logic             w_rxStopSample;
  logic             w_rxLoad;
  logic             w_rxFrameErr;

  // Status and holding registers
  logic [7:0] r_rxData;
  logic       r_rxReady;
  logic       r_overrun;
  logic       r_framingError;
  logic       r_txOverflow;
  logic       w_txIdle;
  logic [7:0] w_status;
  logic [7:0] w_readMux;

  assign w_selStatus  = (addressBus == BASE_ADDR);
  assign w_selData    = (addressBus == DATA_ADDR);
  assign selected     = w_selStatus | w_selData;

  assign w_push       = writeEnBus & w_selData & ~w_fifoFull;
  assign w_overflow   = writeEnBus & w_selData & w_fifoFull;
  assign w_readData   = readEnBus & w_selData;
  assign w_readStatus = readEnBus & w_selStatus;

  // The extra pointer MSB separates "full" (MSBs differ, rest equal) from
  // "empty" (pointers identical).
  assign w_fifoEmpty = (r_wrPtr == r_rdPtr);
  assign w_fifoFull  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                       (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign w_fifoHead  = r_fifoMem[r_rdPtr[PTR_W-1:0]];

  assign w_txBitEnd = (r_txCnt == BIT_LAST);
  // A new frame is pulled either from idle or straight out of the stop bit,
  // which is what makes back-to-back frames gapless.
  assign w_pop = ~w_fifoEmpty &&
                 ((r_txState == TX_IDLE) || ((r_txState == TX_STOP) && w_txBitEnd));

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr[PTR_W-1:0]] <= dataOutBus;
    end
  end

  // FIFO pointers; fullness used for the push decision is the pre-edge value,
  // so a pop on the same edge does not make room for the write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

  // TX serializer: start bit, 8 data bits LSB first, stop bit, each held for
  // CLKS_PER_BIT clocks. txd is registered so it changes only on clock edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_txState  <= TX_IDLE;
      r_txCnt    <= '0;
      r_txBitIdx <= 3'd0;
      r_txShift  <= 8'h00;
      r_txd      <= 1'b1;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          r_txCnt <= '0;
          if (w_pop) begin
            r_txState <= TX_START;
            r_txShift <= w_fifoHead;
            r_txd     <= 1'b0;
          end
        end
        TX_START: begin
          if (w_txBitEnd) begin
            r_txCnt    <= '0;
            r_txBitIdx <= 3'd0;
            r_txState  <= TX_DATA;
            r_txd      <= r_txShift[0];
          end else begin
            r_txCnt <= r_txCnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (w_txBitEnd) begin
            r_txCnt <= '0;
            if (r_txBitIdx == 3'd7) begin
              r_txState <= TX_STOP;
              r_txd     <= 1'b1;
            end else begin
              r_txBitIdx <= r_txBitIdx + 3'd1;
              r_txShift  <= {1'b0, r_txShift[7:1]};
              r_txd      <= r_txShift[1];
            end
          end else begin
            r_txCnt <= r_txCnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (w_txBitEnd) begin
            r_txCnt <= '0;
            if (w_pop) begin
              r_txState <= TX_START;
              r_txShift <= w_fifoHead;
              r_txd     <= 1'b0;
            end else begin
              r_txState <= TX_IDLE;
            end
          end else begin
            r_txCnt <= r_txCnt + CNT_ONE;
          end
        end
        default: begin
          r_txState <= TX_IDLE;
          r_txd     <= 1'b1;
        end
      endcase
    end
  end

  assign txd = r_txd;

  // Two-flop synchronizer for rxd, plus one more flop holding the previous
  // synchronized value for falling-edge detection. All reset to line idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= rxd;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
    end
  end

  assign w_rxFall       = r_rxPrev & ~r_rxSync;
  assign w_rxBitEnd     = (r_rxCnt == BIT_LAST);
  assign w_rxStopSample = (r_rxState == RX_STOP) && w_rxBitEnd;
  assign w_rxLoad       = w_rxStopSample & r_rxSync;
  assign w_rxFrameErr   = w_rxStopSample & ~r_rxSync;

  // RX deserializer: the start bit is checked at its middle, after which
  // every sample lands one full bit later, i.e. near each bit's centre.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxBitIdx <= 3'd0;
      r_rxShift  <= 8'h00;
    end else begin
      case (r_rxState)
        RX_IDLE: begin
          r_rxCnt <= '0;
          if (w_rxFall) begin
            r_rxState <= RX_START;
          end
        end
        RX_START: begin
          if (r_rxCnt == HALF_LAST) begin
            r_rxCnt <= '0;
            if (r_rxSync) begin
              r_rxState <= RX_IDLE;
            end else begin
              r_rxState  <= RX_DATA;
              r_rxBitIdx <= 3'd0;
            end
          end else begin
            r_rxCnt <= r_rxCnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (w_rxBitEnd) begin
            r_rxCnt   <= '0;
            r_rxShift <= {r_rxSync, r_rxShift[7:1]};
            if (r_rxBitIdx == 3'd7) begin
              r_rxState <= RX_STOP;
            end else begin
              r_rxBitIdx <= r_rxBitIdx + 3'd1;
            end
          end else begin
            r_rxCnt <= r_rxCnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (w_rxBitEnd) begin
            r_rxCnt   <= '0;
            r_rxState <= RX_IDLE;
          end else begin
            r_rxCnt <= r_rxCnt + CNT_ONE;
          end
        end
        default: begin
          r_rxState <= RX_IDLE;
        end
      endcase
    end
  end

  // Holding register and sticky flags. Set conditions take priority over
  // clears on the same edge; a data read that coincides with a new byte
  // keeps rxReady and does not count as an overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rxData       <= 8'h00;
      r_rxReady      <= 1'b0;
      r_overrun      <= 1'b0;
      r_framingError <= 1'b0;
      r_txOverflow   <= 1'b0;
    end else begin
      if (w_rxLoad) begin
        r_rxData <= r_rxShift;
      end

      if (w_rxLoad) begin
        r_rxReady <= 1'b1;
      end else if (w_readData) begin
        r_rxReady <= 1'b0;
      end

      if (w_rxLoad && r_rxReady && !w_readData) begin
        r_overrun <= 1'b1;
      end else if (w_readStatus) begin
        r_overrun <= 1'b0;
      end

      if (w_rxFrameErr) begin
        r_framingError <= 1'b1;
      end else if (w_readStatus) begin
        r_framingError <= 1'b0;
      end

      if (w_overflow) begin
        r_txOverflow <= 1'b1;
      end else if (w_readStatus) begin
        r_txOverflow <= 1'b0;
      end
    end
  end

  assign w_txIdle = w_fifoEmpty && (r_txState == TX_IDLE);
  assign w_status = {2'b00, r_txOverflow, r_framingError, r_overrun,
                     w_txIdle, ~w_fifoFull, r_rxReady};

  // Read mux: unselected addresses return zero so the CPU can OR buses.
  always_comb begin
    w_readMux = 8'h00;
    if (w_selStatus) begin
      w_readMux = w_status;
    end else if (w_selData) begin
      w_readMux = r_rxData;
    end
  end

  assign dataInBus = w_readMux;

endmodule

// File: tb/tb_mux_port.sv
// ---------------------------------------------------------------------------
// tb_mux_port
//
// Directed bench for mux_port with CLKS_PER_BIT=4 and TX_DEPTH=4. Stimulus
// queues expected observations; a monitor on the falling clock edge pops
// each one and compares it against the DUT output it names.
// ---------------------------------------------------------------------------
module tb_mux_port;

  localparam int          CPB       = 4;
  localparam logic [15:0] BASE      = 16'hF200;
  localparam logic [15:0] DATA_ADDR = 16'hF201;

  localparam int OBS_DATA = 0;
  localparam int OBS_TXD  = 1;
  localparam int OBS_SEL  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addressBus;
  logic        writeEnBus;
  logic        readEnBus;
  logic [7:0]  dataOutBus;
  logic [7:0]  dataInBus;
  logic        selected;
  logic        txd;
  logic        rxd;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } obs_t;

  obs_t sbQueue[$];
  int   nChecks = 0;
  int   nFails  = 0;

  logic [7:0] txBytes [6];
  logic [9:0] frameBits;

  mux_port #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .TX_DEPTH    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addressBus(addressBus),
    .writeEnBus(writeEnBus),
    .readEnBus (readEnBus),
    .dataOutBus(dataOutBus),
    .dataInBus (dataInBus),
    .selected  (selected),
    .txd       (txd),
    .rxd       (rxd)
  );

  always #5 clock = ~clock;

  // Monitor: drain every queued expectation at the falling edge, mid-cycle,
  // well away from the rising edge where the DUT updates.
  always @(negedge clock) begin : monitor
    obs_t       item;
    logic [7:0] act;
    while (sbQueue.size() > 0) begin
      item = sbQueue.pop_front();
      case (item.kind)
        OBS_DATA: act = dataInBus;
        OBS_TXD:  act = {7'b0, txd};
        default:  act = {7'b0, selected};
      endcase
      nChecks++;
      if (act !== item.exp) begin
        nFails++;
        $display("[TB] FAIL %s: got %02h, expected %02h at %0t", item.name, act, item.exp, $time);
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic rd,
                               input logic [7:0] data);
    addressBus = addr;
    writeEnBus = wr;
    readEnBus  = rd;
    dataOutBus = data;
  endtask

  task automatic checkOutput(input int kind, input logic [7:0] exp, input string name);
    obs_t item;
    item.kind = kind;
    item.exp  = exp;
    item.name = name;
    sbQueue.push_back(item);
  endtask

  // Drive one 8N1 frame on rxd, LSB first, CPB clocks per bit.
  task automatic sendRxFrame(input logic [7:0] value, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, value, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd = bits[b];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
  endtask

  initial begin
    txBytes[0] = 8'h11;
    txBytes[1] = 8'h22;
    txBytes[2] = 8'h33;
    txBytes[3] = 8'h44;
    txBytes[4] = 8'h55;
    txBytes[5] = 8'h66;
    rxd = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (3) tick();

    // Reset state, checked while reset is still asserted
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h06, "resetStatus");
    checkOutput(OBS_TXD, 8'h01, "resetTxd");
    tick();
    reset = 1'b0;
    tick();

    // Address decode
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h06, "statusAfterReset");
    checkOutput(OBS_SEL, 8'h01, "selStatus");
    tick();
    applyStimulus(DATA_ADDR, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h00, "rxDataAfterReset");
    checkOutput(OBS_SEL, 8'h01, "selData");
    tick();
    applyStimulus(16'hF1FF, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h00, "readBelowBase");
    checkOutput(OBS_SEL, 8'h00, "selBelowBase");
    tick();
    applyStimulus(16'hF202, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h00, "readAboveData");
    checkOutput(OBS_SEL, 8'h00, "selAboveData");
    tick();

    // Writes to the status address or outside the block are ignored
    applyStimulus(BASE, 1'b1, 1'b0, 8'hFF);
    tick();
    applyStimulus(16'hF202, 1'b1, 1'b0, 8'h55);
    tick();
    applyStimulus(16'h0201, 1'b1, 1'b1, 8'h55);
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput(OBS_DATA, 8'h06, "ignoredWritesStatus");
    checkOutput(OBS_TXD, 8'h01, "ignoredWritesTxd");
    tick();

    // Single frame 8'hA5 from idle
    applyStimulus(DATA_ADDR, 1'b1, 1'b0, 8'hA5);
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_TXD, 8'h01, "txdOnWriteEdge");
    checkOutput(OBS_DATA, 8'h02, "statusQueued");
    tick();
    frameBits = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        checkOutput(OBS_TXD, {7'b0, frameBits[b]}, "txA5Bit");
        if (b == 9 && c == CPB - 1) begin
          checkOutput(OBS_DATA, 8'h02, "statusDuringStop");
        end
        tick();
      end
    end
    checkOutput(OBS_DATA, 8'h06, "statusAfterA5");
    checkOutput(OBS_TXD, 8'h01, "txdIdleAfterA5");
    tick();

    // Six writes on consecutive edges: five accepted, the sixth dropped
    for (int i = 0; i < 6; i++) begin
      applyStimulus(DATA_ADDR, 1'b1, 1'b0, txBytes[i]);
      tick();
    end
    // Now four clocks into the first frame
    applyStimulus(BASE, 1'b0, 1'b1, 8'h00);
    checkOutput(OBS_DATA, 8'h20, "statusOverflowFull");
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h00, "overflowCleared");
    tick();
    for (int cyc = 6; cyc < 200; cyc++) begin
      frameBits = {1'b1, txBytes[cyc / 40], 1'b0};
      checkOutput(OBS_TXD, {7'b0, frameBits[(cyc % 40) / CPB]}, "txBurstBit");
      tick();
    end
    checkOutput(OBS_TXD, 8'h01, "txdAfterBurst");
    checkOutput(OBS_DATA, 8'h06, "statusAfterBurst");
    tick();

    // Receive 8'h3C
    sendRxFrame(8'h3C, 1'b1);
    repeat (4) tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h07, "statusRxReady");
    tick();
    applyStimulus(DATA_ADDR, 1'b0, 1'b1, 8'h00);
    checkOutput(OBS_DATA, 8'h3C, "rxData3C");
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h06, "rxReadyCleared");
    tick();

    // Two frames without a read in between: overrun
    sendRxFrame(8'hA1, 1'b1);
    sendRxFrame(8'h5E, 1'b1);
    repeat (4) tick();
    applyStimulus(DATA_ADDR, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h5E, "rxDataSecond");
    tick();
    applyStimulus(BASE, 1'b0, 1'b1, 8'h00);
    checkOutput(OBS_DATA, 8'h0F, "statusOverrun");
    tick();
    applyStimulus(DATA_ADDR, 1'b0, 1'b1, 8'h00);
    checkOutput(OBS_DATA, 8'h5E, "rxDataAfterStatusRead");
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h06, "overrunAndReadyCleared");
    tick();

    // One-clock low glitch: false start, nothing loaded
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (20) tick();
    checkOutput(OBS_DATA, 8'h06, "statusAfterGlitch");
    tick();
    applyStimulus(DATA_ADDR, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h5E, "rxDataAfterGlitch");
    tick();

    // Stop bit sampled low: framing error, byte discarded
    sendRxFrame(8'h77, 1'b0);
    repeat (4) tick();
    applyStimulus(BASE, 1'b0, 1'b1, 8'h00);
    checkOutput(OBS_DATA, 8'h16, "statusFramingError");
    tick();
    applyStimulus(DATA_ADDR, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h5E, "rxDataAfterFramingError");
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    checkOutput(OBS_DATA, 8'h06, "framingErrorCleared");
    tick();

    // Reset in the middle of a TX frame
    applyStimulus(DATA_ADDR, 1'b1, 1'b0, 8'h3C);
    tick();
    applyStimulus(BASE, 1'b0, 1'b0, 8'h00);
    repeat (10) tick();
    checkOutput(OBS_TXD, 8'h00, "txdMidFrame");
    checkOutput(OBS_DATA, 8'h02, "statusMidFrame");
    tick();
    reset = 1'b1;
    checkOutput(OBS_TXD, 8'h01, "txdOnReset");
    checkOutput(OBS_DATA, 8'h06, "statusOnReset");
    tick();
    reset = 1'b0;
    tick();
    checkOutput(OBS_DATA, 8'h06, "statusAfterAbort");
    repeat (8) tick();
    checkOutput(OBS_TXD, 8'h01, "txdStaysIdleAfterAbort");
    tick();
    tick();

    if (sbQueue.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
